// File: rtl/datapath_pkg.sv
// datapath_pkg -- shared datapath sizing for the register file slice.
//
// Provides the default register width, address width, register count and
// the index of the hardwired zero register. Consumers take these as
// parameter defaults so a narrower/wider build only needs new overrides.
package datapath_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 32;
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port -- one combinational read port of the register file.
//
// Selects the addressed register from the storage array, forces the zero
// register to read 0, and (when built with REG_FILE_BYPASS_EN) forwards
// the write data of a same-cycle write to the same register.
//
// Build option:
//   REG_FILE_BYPASS_EN  defined -> write-before-read forwarding enabled
//                       undefined -> read shows stored value until the edge
//
// Ports:
//   regs     in   storage array (2**ADDR_WIDTH x DATA_WIDTH)
//   addr     in   read address
//   rst      in   reset; suppresses forwarding while high
//   wr_en    in   write enable of the shared write port
//   wr_addr  in   write address of the shared write port
//   wr_data  in   write data of the shared write port
//   rd_data  out  read data, zero cycles from addr change
module reg_file_read_port
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = datapath_pkg::ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic byp_hit;

  // Forward only a write that will actually land at the next edge:
  // enabled, not overridden by reset, and not aimed at the zero register.
  assign byp_hit = wr_en && !rst && (wr_addr == addr) && (wr_addr != ZERO_ADDR);

  always_comb begin
    rd_data = regs[addr];
    if (addr == ZERO_ADDR) begin
      rd_data = '0;
    end else if (BYPASS && byp_hit) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// reg_file_32x32 -- 2-read / 1-write register file with hardwired zero reg.
//
// Build option:
//   REG_FILE_BYPASS_EN  defined -> same-cycle write data forwarded to reads
//
// Ports:
//   Clk        in   clock, all state updates on rising edge
//   Rst        in   synchronous active-high reset, clears every register
//   ReadReg1   in   read port 1 address (rs)
//   ReadReg2   in   read port 2 address (rt)
//   WriteReg   in   write address (RegDst mux output)
//   WriteData  in   writeback data
//   RegWrite   in   write enable
//   ReadData1  out  read port 1 data (combinational)
//   ReadData2  out  read port 2 data (combinational)
module reg_file_32x32
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = datapath_pkg::ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Reset wins over a coincident write. The zero register is never
  // written, so after the first reset it holds 0; the read ports force 0
  // for it anyway so it reads correctly even before any reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && (WriteReg != ZERO_ADDR)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_port1 (
    .regs    (regs),
    .addr    (ReadReg1),
    .rst     (Rst),
    .wr_en   (RegWrite),
    .wr_addr (WriteReg),
    .wr_data (WriteData),
    .rd_data (ReadData1)
  );

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_port2 (
    .regs    (regs),
    .addr    (ReadReg2),
    .rst     (Rst),
    .wr_en   (RegWrite),
    .wr_addr (WriteReg),
    .wr_data (WriteData),
    .rd_data (ReadData2)
  );

endmodule

// File: tb/tb_reg_file_32x32.sv
module tb_reg_file_32x32;

  logic        Clk;
  logic        Rst;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int checks;
  int failures;

  reg_file_32x32 dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // 1 further unit later, well away from either clock edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    RegWrite  = 1'b1;
    WriteReg  = a;
    WriteData = d;
    tick();
    RegWrite  = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      checks++;
      if (ReadData1 !== 32'h0) begin
        failures++;
        $display("FAIL reset_rd1 reg=%0d got=%h exp=%h", i, ReadData1, 32'h0);
      end
      checks++;
      if (ReadData2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_rd2 reg=%0d got=%h exp=%h", 31 - i, ReadData2, 32'h0);
      end
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd8, 32'hDEADBEEF);
    ReadReg1 = 5'd8;
    ReadReg2 = 5'd9;
    #1;
    checks++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_rd_reg8 got=%h exp=%h", ReadData1, 32'hDEADBEEF);
    end
    checks++;
    if (ReadData2 !== 32'h0) begin
      failures++;
      $display("FAIL wr_rd_reg9 got=%h exp=%h", ReadData2, 32'h0);
    end
    // A second write elsewhere must leave reg 8 alone; both ports on reg 31.
    write_reg(5'd31, 32'hA5A5_0F0F);
    ReadReg1 = 5'd31;
    ReadReg2 = 5'd31;
    #1;
    checks++;
    if (ReadData1 !== 32'hA5A5_0F0F) begin
      failures++;
      $display("FAIL same_addr_rd1 got=%h exp=%h", ReadData1, 32'hA5A5_0F0F);
    end
    checks++;
    if (ReadData2 !== 32'hA5A5_0F0F) begin
      failures++;
      $display("FAIL same_addr_rd2 got=%h exp=%h", ReadData2, 32'hA5A5_0F0F);
    end
    ReadReg1 = 5'd8;
    ReadReg2 = 5'd1;
    #1;
    checks++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL other_reg_kept got=%h exp=%h", ReadData1, 32'hDEADBEEF);
    end
    checks++;
    if (ReadData2 !== 32'h0) begin
      failures++;
      $display("FAIL reg1_untouched got=%h exp=%h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_zero_reg();
    RegWrite  = 1'b1;
    WriteReg  = 5'd0;
    WriteData = 32'h12345678;
    ReadReg1  = 5'd0;
    ReadReg2  = 5'd0;
    #1;
    checks++;
    if (ReadData1 !== 32'h0) begin
      failures++;
      $display("FAIL zero_during_write got=%h exp=%h", ReadData1, 32'h0);
    end
    tick();
    RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 32'h0) begin
      failures++;
      $display("FAIL zero_after_write_rd1 got=%h exp=%h", ReadData1, 32'h0);
    end
    checks++;
    if (ReadData2 !== 32'h0) begin
      failures++;
      $display("FAIL zero_after_write_rd2 got=%h exp=%h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_pre;
`ifdef REG_FILE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    write_reg(5'd5, 32'h11);
    RegWrite  = 1'b1;
    WriteReg  = 5'd5;
    WriteData = 32'h22;
    ReadReg1  = 5'd8;
    ReadReg2  = 5'd5;
    #1;
    checks++;
    if (ReadData2 !== exp_pre) begin
      failures++;
      $display("FAIL bypass_pre_edge got=%h exp=%h", ReadData2, exp_pre);
    end
    checks++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_other_port got=%h exp=%h", ReadData1, 32'hDEADBEEF);
    end
    tick();
    RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData2 !== 32'h22) begin
      failures++;
      $display("FAIL bypass_post_edge got=%h exp=%h", ReadData2, 32'h22);
    end
    // With reset high, the pending write must not be forwarded.
    Rst       = 1'b1;
    RegWrite  = 1'b1;
    WriteReg  = 5'd5;
    WriteData = 32'h33;
    #1;
    checks++;
    if (ReadData2 !== 32'h22) begin
      failures++;
      $display("FAIL bypass_rst_suppress got=%h exp=%h", ReadData2, 32'h22);
    end
    tick();
    Rst      = 1'b0;
    RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData2 !== 32'h0) begin
      failures++;
      $display("FAIL bypass_rst_clear got=%h exp=%h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_reset_priority();
    write_reg(5'd3, 32'h77);
    write_reg(5'd9, 32'h99);
    Rst       = 1'b1;
    RegWrite  = 1'b1;
    WriteReg  = 5'd3;
    WriteData = 32'hFF;
    tick();
    Rst      = 1'b0;
    RegWrite = 1'b0;
    ReadReg1 = 5'd3;
    ReadReg2 = 5'd9;
    #1;
    checks++;
    if (ReadData1 !== 32'h0) begin
      failures++;
      $display("FAIL rst_vs_write_reg3 got=%h exp=%h", ReadData1, 32'h0);
    end
    checks++;
    if (ReadData2 !== 32'h0) begin
      failures++;
      $display("FAIL rst_clears_reg9 got=%h exp=%h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_disabled_write();
    write_reg(5'd7, 32'h55);
    RegWrite  = 1'b0;
    WriteReg  = 5'd7;
    WriteData = 32'hAA;
    ReadReg1  = 5'd7;
    ReadReg2  = 5'd7;
    repeat (3) tick();
    #1;
    checks++;
    if (ReadData1 !== 32'h55) begin
      failures++;
      $display("FAIL disabled_write_rd1 got=%h exp=%h", ReadData1, 32'h55);
    end
    checks++;
    if (ReadData2 !== 32'h55) begin
      failures++;
      $display("FAIL disabled_write_rd2 got=%h exp=%h", ReadData2, 32'h55);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    Rst       = 1'b0;
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    #2;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_reset_priority();
    test_disabled_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_file_32x32.md
REG_FILE_32X32 -- requirements
Module: reg_file_32x32

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register address width (2**ADDR_WIDTH registers).
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ReadReg1  input  ADDR_WIDTH  read port 1 address (rs).
REQ-006 SHALL have port ReadReg2  input  ADDR_WIDTH  read port 2 address (rt).
REQ-007 SHALL have port WriteReg  input  ADDR_WIDTH  write address, driven by the 5-bit 2:1 RegDst destination mux output.
REQ-008 SHALL have port WriteData  input  DATA_WIDTH  write data from the writeback stage.
REQ-009 SHALL have port RegWrite  input  1  write enable.
REQ-010 SHALL have port ReadData1  output  DATA_WIDTH  read port 1 data.
REQ-011 SHALL have port ReadData2  output  DATA_WIDTH  read port 2 data.

Function
REQ-012 SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits.
REQ-013 SHALL write WriteData into register WriteReg on the Clk rising edge when RegWrite=1 and Rst=0.
REQ-014 SHALL ignore writes when WriteReg=0; register 0 always holds 0.
REQ-015 SHALL drive ReadData1/ReadData2 combinationally from the addressed register, with zero cycles of latency from the address change.
REQ-016 SHALL return 0 on any read port addressed to register 0, regardless of the write inputs.
REQ-017 SHALL let both read ports address the same register and return identical data.
REQ-018 SHALL perform exactly one write per cycle; on a write, read ports addressing other registers are unaffected.
REQ-019 SHALL give a write asserted with RegWrite=0 no effect, whatever WriteReg or WriteData carry.

Reset
REQ-020 SHALL clear all registers to 0 on a Clk rising edge with Rst=1.
REQ-021 SHALL give Rst priority over a simultaneous write; that write is discarded.
REQ-022 SHALL drive both read outputs to 0 from the first Rst edge until a later write.
REQ-023 SHALL clear all registers when Rst is asserted mid-operation, including any in-flight write.
REQ-024 SHALL suppress the bypass path (REQ-025) while Rst=1.

Configuration
REQ-025 With macro REG_FILE_BYPASS_EN defined, SHALL forward WriteData to ReadDataN in the same cycle when RegWrite=1, Rst=0, WriteReg=ReadRegN and WriteReg!=0 (write-before-read).
REQ-026 Without REG_FILE_BYPASS_EN, ReadDataN SHALL show the stored value before the write and the new value only after the Clk edge.

Structure
REQ-027 SHALL take REG_COUNT (32), ZERO_REG (0), DATA_WIDTH and ADDR_WIDTH defaults from a shared package datapath_pkg.
REQ-028 SHALL implement each read port as an instance of sub-module reg_file_read_port (array select, zero-register forcing, optional bypass), instantiated twice.

Verification
REQ-029 Reset: Rst=1 for one edge, then read regs 0..31 -> all return 0x00000000.
REQ-030 Write/read: RegWrite=1, WriteReg=8, WriteData=0xDEADBEEF, one edge -> ReadReg1=8 returns 0xDEADBEEF, ReadReg2=9 returns 0.
REQ-031 Zero register: write 0x12345678 to reg 0 -> ReadReg1=0 returns 0 after the edge, and during the write cycle with the bypass macro defined.
REQ-032 Bypass: reg 5 holds 0x11, same cycle write 0x22 to reg 5 with ReadReg2=5 -> ReadData2=0x22 before the edge with REG_FILE_BYPASS_EN, 0x11 without; 0x22 after the edge in both builds.
REQ-033 Rst vs write: Rst=1 and RegWrite=1, WriteReg=3, WriteData=0xFF on the same edge -> reg 3 reads 0.
REQ-034 Disabled write: RegWrite=0, WriteReg=7, WriteData=0xAA over 3 edges -> reg 7 keeps its prior value 0x55.
